pciecfg_engine: RTL
===================

Name: pciecfg_engine

Overview:
- Executes NetTLP PCIe-configuration requests popped from the UDP-side request FIFO against the hard PCIe core's cfg_mgmt port.
- Pushes one response per accessed dword into a reply FIFO for the UDP transmit path.
- Generalises the single-dword read/write packet with a parametrised dword-address width, a burst-read opcode, a per-access timeout and status codes.

Parameters:
- ADDR_W, 10, config-space dword-address width.
- BURST_MAX, 16, maximum dwords per burst read (1..256).
- TIMEOUT_CYC, 1024, cycles to wait for cfg_mgmt_rd_wr_done before aborting an access.

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- req_empty  in  1  request FIFO empty.
- req_rd_en  out  1  request FIFO pop; standard FIFO, req_dout valid the cycle after the pop.
- req_dout  in  54+ADDR_W  {udp_check[15:0], opcode[1:0], byte_mask[3:0], dwaddr[ADDR_W-1:0], data[31:0]}.
- cfg_mgmt_dwaddr  out  ADDR_W  access address.
- cfg_mgmt_byte_en  out  4  write byte enables.
- cfg_mgmt_di  out  32  write data.
- cfg_mgmt_rd_en  out  1  read strobe, held until done.
- cfg_mgmt_wr_en  out  1  write strobe, held until done.
- cfg_mgmt_do  in  32  read data, valid with done.
- cfg_mgmt_rd_wr_done  in  1  access complete.
- rsp_full  in  1  reply FIFO full.
- rsp_wr_en  out  1  reply push.
- rsp_din  out  56+ADDR_W  {udp_check, status[1:0], opcode, byte_mask, dwaddr, data}.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE.
- Opcodes: 00 RD (single dword); 01 WR (byte_mask applied as byte_en); 10 RD_BURST (length = data[7:0], reads dwaddr..dwaddr+len-1); 11 illegal.
- Status codes: 00 OK; 01 TIMEOUT; 10 BAD_OPC; 11 BAD_LEN.

State machine:
- IDLE: when !req_empty, assert req_rd_en for exactly 1 cycle, then go to LATCH.
- LATCH: capture req_dout into working registers; go to CHECK.
- CHECK:
  - opcode 11 -> RESP with BAD_OPC.
  - RD_BURST with len==0, len>BURST_MAX, or dwaddr+len-1 > 2^ADDR_W-1 (no wrap-around permitted) -> RESP with BAD_LEN, no cfg access.
  - Otherwise load remaining count (1 for RD/WR) and go to ACCESS.
- ACCESS:
  - Drive addr/byte_en/di and the strobe (rd_en for RD/RD_BURST, wr_en for WR) from cycle 1; hold them stable.
  - On done: latch cfg_mgmt_do (reads) or echo the request data (writes), status OK, drop strobe the same edge, go to RESP.
  - Timeout counter reaches TIMEOUT_CYC with no done: drop strobe, data=0, status TIMEOUT, go to RESP.
  - A done arriving in the same cycle as timeout expiry counts as OK.
- RESP:
  - Assert rsp_wr_en for 1 cycle when !rsp_full; stall without pushing while rsp_full.
  - Response dwaddr = current access address; byte_mask = request byte_mask (4'hF for bursts).
  - After push: if remaining>1 and status OK, decrement remaining, increment address, go to ACCESS; else go to IDLE.
  - A TIMEOUT mid-burst ends the burst; remaining dwords are not responded.
- Latency: single RD/WR with done on the first strobe cycle gives pop-to-push = 4 cycles (pop, LATCH, CHECK, ACCESS, push in RESP).
- Only one request in flight; strobes are never asserted in any state other than ACCESS; rd_en and wr_en are never both high.
- rst mid-access: strobes deassert on the next edge, the working request is discarded, no response is emitted.
- Checksum (udp_check) is passed through unmodified; not verified here.

Optional Feature:
- Macro: PCIECFG_ENGINE_STATS_EN.
- Defined: adds outputs stat_req[31:0], stat_timeout[15:0], stat_err[15:0]; all reset to 0.
  - stat_req increments per request entering CHECK.
  - stat_timeout increments per TIMEOUT response.
  - stat_err increments per BAD_OPC/BAD_LEN response.
  - Counters saturate at all-ones.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- RD dwaddr=0x000, done after 2 cycles with do=0x10EE7022 -> one response {status=00, dwaddr=0x000, data=0x10EE7022}, udp_check echoed.
- WR dwaddr=0x001, byte_mask=0011, data=0x00000006 -> wr_en with byte_en=0011, di=0x6, held until done; response status 00, data 0x6.
- RD_BURST dwaddr=0x004, len=6 -> six accesses at 0x004..0x009 and six responses in order; rsp_full held 5 cycles mid-burst -> no push during stall, no response lost.
- RD_BURST len=0, len=BURST_MAX+1, and dwaddr=0x3FE len=4 -> each yields one BAD_LEN response and no strobe; opcode 11 -> BAD_OPC.
- done never asserted -> strobe dropped at exactly TIMEOUT_CYC cycles, response status 01 data 0; next queued request then proceeds normally.
- rst asserted during ACCESS -> all outputs 0 next cycle, no response; the following request executes correctly.

Source files
------------

// File: rtl/pciecfg_engine.sv
// NetTLP configuration-request engine: pops requests, drives cfg_mgmt, pushes one reply per dword.
// Optional statistics counters are enabled with `define PCIECFG_ENGINE_STATS_EN.
module pciecfg_engine #(
   parameter int ADDR_W      = 10,
   parameter int BURST_MAX   = 16,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_empty,
   output logic                 req_rd_en,
   input  logic [53+ADDR_W:0]   req_dout,
   output logic [ADDR_W-1:0]    cfg_mgmt_dwaddr,
   output logic [3:0]           cfg_mgmt_byte_en,
   output logic [31:0]          cfg_mgmt_di,
   output logic                 cfg_mgmt_rd_en,
   output logic                 cfg_mgmt_wr_en,
   input  logic [31:0]          cfg_mgmt_do,
   input  logic                 cfg_mgmt_rd_wr_done,
   input  logic                 rsp_full,
   output logic                 rsp_wr_en,
   output logic [55+ADDR_W:0]   rsp_din,
   output logic                 busy
`ifdef PCIECFG_ENGINE_STATS_EN
   ,
   output logic [31:0]          stat_req,
   output logic [15:0]          stat_timeout,
   output logic [15:0]          stat_err
`endif
);

   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   localparam int SUM_W = ADDR_W + 9;

   localparam logic [1:0] OPC_RD    = 2'b00;
   localparam logic [1:0] OPC_WR    = 2'b01;
   localparam logic [1:0] OPC_BURST = 2'b10;
   localparam logic [1:0] OPC_BAD   = 2'b11;

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_TIMEOUT = 2'b01;
   localparam logic [1:0] ST_BAD_OPC = 2'b10;
   localparam logic [1:0] ST_BAD_LEN = 2'b11;

   typedef enum logic [2:0] {S_IDLE, S_LATCH, S_CHECK, S_ACCESS, S_RESP} state_t;

   state_t              state_reg, state_next;
   logic [15:0]         udp_check_reg;
   logic [1:0]          opcode_reg;
   logic [3:0]          mask_reg;
   logic [ADDR_W-1:0]   addr_reg;
   logic [31:0]         data_reg;
   logic [1:0]          status_reg;
   logic [8:0]          remaining_reg;
   logic [TMO_W-1:0]    tmo_reg;

   logic [7:0]          burst_len;
   logic [SUM_W-1:0]    end_sum;
   logic                len_bad;
   logic                check_bad;
   logic                tmo_expired;

   assign burst_len   = data_reg[7:0];
   // One past the last dword of the burst; must not exceed the top of config space.
   assign end_sum     = SUM_W'(addr_reg) + SUM_W'(burst_len);
   assign len_bad     = (burst_len == 8'd0) || ({1'b0, burst_len} > 9'(BURST_MAX)) ||
                        (end_sum > (SUM_W'(1) << ADDR_W));
   assign check_bad   = (opcode_reg == OPC_BAD) || ((opcode_reg == OPC_BURST) && len_bad);
   assign tmo_expired = (tmo_reg == TMO_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (rst) state_reg <= S_IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:   if (!req_empty) state_next = S_LATCH;
         S_LATCH:  state_next = S_CHECK;
         S_CHECK:  state_next = check_bad ? S_RESP : S_ACCESS;
         S_ACCESS: if (cfg_mgmt_rd_wr_done || tmo_expired) state_next = S_RESP;
         S_RESP: begin
            if (!rsp_full)
               state_next = ((remaining_reg > 9'd1) && (status_reg == ST_OK)) ? S_ACCESS : S_IDLE;
         end
         default:  state_next = S_IDLE;
      endcase
   end

   always_comb begin
      req_rd_en      = (state_reg == S_IDLE) && !req_empty && !rst;
      cfg_mgmt_rd_en = (state_reg == S_ACCESS) && (opcode_reg != OPC_WR);
      cfg_mgmt_wr_en = (state_reg == S_ACCESS) && (opcode_reg == OPC_WR);
      rsp_wr_en      = (state_reg == S_RESP) && !rsp_full;
      busy           = (state_reg != S_IDLE);
   end

   assign cfg_mgmt_dwaddr  = addr_reg;
   assign cfg_mgmt_byte_en = mask_reg;
   assign cfg_mgmt_di      = data_reg;
   assign rsp_din          = {udp_check_reg, status_reg, opcode_reg, mask_reg, addr_reg, data_reg};

   always_ff @(posedge clk) begin
      if (rst) begin
         udp_check_reg <= '0;
         opcode_reg    <= '0;
         mask_reg      <= '0;
         addr_reg      <= '0;
         data_reg      <= '0;
         status_reg    <= '0;
         remaining_reg <= '0;
         tmo_reg       <= '0;
      end else begin
         case (state_reg)
            S_LATCH: begin
               {udp_check_reg, opcode_reg, mask_reg, addr_reg, data_reg} <= req_dout;
               status_reg <= ST_OK;
            end
            S_CHECK: begin
               tmo_reg <= '0;
               if (opcode_reg == OPC_BAD) begin
                  status_reg <= ST_BAD_OPC;
                  data_reg   <= '0;
               end else if (opcode_reg == OPC_BURST) begin
                  mask_reg <= 4'hF;
                  if (len_bad) begin
                     status_reg <= ST_BAD_LEN;
                     data_reg   <= '0;
                  end else begin
                     remaining_reg <= {1'b0, burst_len};
                  end
               end else begin
                  remaining_reg <= 9'd1;
               end
            end
            S_ACCESS: begin
               // A done coinciding with expiry wins, so it is tested first.
               if (cfg_mgmt_rd_wr_done) begin
                  status_reg <= ST_OK;
                  if (opcode_reg != OPC_WR) data_reg <= cfg_mgmt_do;
               end else if (tmo_expired) begin
                  status_reg <= ST_TIMEOUT;
                  data_reg   <= '0;
               end else begin
                  tmo_reg <= tmo_reg + 1'b1;
               end
            end
            S_RESP: begin
               if (!rsp_full && (remaining_reg > 9'd1) && (status_reg == ST_OK)) begin
                  remaining_reg <= remaining_reg - 1'b1;
                  addr_reg      <= addr_reg + 1'b1;
                  tmo_reg       <= '0;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef PCIECFG_ENGINE_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_req     <= '0;
         stat_timeout <= '0;
         stat_err     <= '0;
      end else begin
         if ((state_reg == S_LATCH) && (stat_req != '1))
            stat_req <= stat_req + 1'b1;
         if ((state_reg == S_ACCESS) && !cfg_mgmt_rd_wr_done && tmo_expired && (stat_timeout != '1))
            stat_timeout <= stat_timeout + 1'b1;
         if ((state_reg == S_CHECK) && check_bad && (stat_err != '1))
            stat_err <= stat_err + 1'b1;
      end
   end
`endif

endmodule
